// File: rtl/sigmoid_stim_checker.sv
// Stimulus driver and result checker for a sigmoid DUT: streams N_PAT patterns, scores results against golden ROM.
// Optional SIGDRV_MAXERR_EN adds a running max-absolute-error tracker on o_max_err.
module sigmoid_stim_checker #(
    parameter int unsigned N_PAT   = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic [7:0]  o_x_addr,
    input  logic [7:0]  i_pat_x,
    output logic [7:0]  o_g_addr,
    input  logic [15:0] i_gold_y,
    output logic [7:0]  o_x,
    output logic        o_in_valid,
    input  logic        i_out_valid,
    input  logic [15:0] i_y,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err_code,
    output logic [8:0]  o_rx_count,
    output logic [39:0] o_mse,
    output logic [15:0] o_cycles,
    output logic [15:0] o_max_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [8:0]    NP     = 9'(N_PAT);
    localparam logic [8:0]    NP_M1  = 9'(N_PAT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [8:0]    sc;
    logic [TW-1:0] tcnt;
    logic          got_first;

    logic          accept;
    logic          drop_evt;
    logic          tmo_evt;
    logic [15:0]   diff;
    logic [31:0]   sq;

    assign diff = (i_y >= i_gold_y) ? (i_y - i_gold_y) : (i_gold_y - i_y);
    assign sq   = 32'(diff) * 32'(diff);

    // Address 0 outside RUN so the entry edge captures pattern 0 regardless of leftover sc.
    assign o_x_addr = (state == S_RUN) ? sc[7:0] : '0;
    assign o_g_addr = o_rx_count[7:0];

    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        accept   = (state == S_RUN) && i_out_valid && (o_rx_count < NP);
        drop_evt = (state == S_RUN) && got_first && !i_out_valid && (o_rx_count < NP);
        tmo_evt  = (state == S_RUN) && !got_first && !i_out_valid && (tcnt == T_LAST);
        case (state)
            S_RUN: begin
                o_busy = 1'b1;
                if (accept && (o_rx_count == NP_M1)) begin
                    state_nx = S_DONE;
                end else if (drop_evt || tmo_evt) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    state_nx = S_RUN;
                end
            end
            default: begin
                if (i_start) begin
                    state_nx = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sc         <= '0;
            tcnt       <= '0;
            got_first  <= 1'b0;
            o_x        <= '0;
            o_in_valid <= 1'b0;
            o_err_code <= '0;
            o_rx_count <= '0;
            o_mse      <= '0;
            o_cycles   <= '0;
        end else begin
            state <= state_nx;
            if (state != S_RUN) begin
                if (i_start) begin
                    sc         <= 9'd1;
                    o_x        <= i_pat_x;
                    o_in_valid <= 1'b1;
                    tcnt       <= '0;
                    got_first  <= 1'b0;
                    o_err_code <= '0;
                    o_rx_count <= '0;
                    o_mse      <= '0;
                    o_cycles   <= '0;
                end else begin
                    o_in_valid <= 1'b0;
                end
            end else if (drop_evt) begin
                o_err_code <= 2'b10;
                o_in_valid <= 1'b0;
            end else if (tmo_evt) begin
                o_err_code <= 2'b01;
                o_in_valid <= 1'b0;
            end else begin
                if (sc < NP) begin
                    o_x        <= i_pat_x;
                    o_in_valid <= 1'b1;
                    sc         <= sc + 9'd1;
                end else begin
                    o_in_valid <= 1'b0;
                end
                if (o_cycles != '1) begin
                    o_cycles <= o_cycles + 16'd1;
                end
                if (accept) begin
                    got_first  <= 1'b1;
                    o_rx_count <= o_rx_count + 9'd1;
                    o_mse      <= o_mse + {8'd0, sq};
                end else if (!got_first) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

`ifdef SIGDRV_MAXERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_max_err <= '0;
        end else if ((state != S_RUN) && i_start) begin
            o_max_err <= '0;
        end else if (accept && (diff > o_max_err)) begin
            o_max_err <= diff;
        end
    end
`else
    assign o_max_err = '0;
`endif

endmodule

// File: tb/tb_sigmoid_stim_checker.sv
// Randomized bench for sigmoid_stim_checker: a delay-line DUT model plus arithmetic expectations per run.
module tb_sigmoid_stim_checker;

    localparam int N        = 256;
    localparam int TMO      = 1024;
    localparam int M_NORMAL = 0;
    localparam int M_DROP   = 1;
    localparam int M_NEVER  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  o_x_addr;
    logic [7:0]  i_pat_x;
    logic [7:0]  o_g_addr;
    logic [15:0] i_gold_y;
    logic [7:0]  o_x;
    logic        o_in_valid;
    logic        i_out_valid;
    logic [15:0] i_y;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_err_code;
    logic [8:0]  o_rx_count;
    logic [39:0] o_mse;
    logic [15:0] o_cycles;
    logic [15:0] o_max_err;

    logic [7:0]  pat_x [N];
    logic [15:0] gold  [N];
    int          e_arr [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign i_pat_x  = pat_x[o_x_addr];
    assign i_gold_y = gold[o_g_addr];

    sigmoid_stim_checker #(.N_PAT(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_x_addr(o_x_addr), .i_pat_x(i_pat_x),
        .o_g_addr(o_g_addr), .i_gold_y(i_gold_y),
        .o_x(o_x), .o_in_valid(o_in_valid),
        .i_out_valid(i_out_valid), .i_y(i_y),
        .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code),
        .o_rx_count(o_rx_count), .o_mse(o_mse), .o_cycles(o_cycles),
        .o_max_err(o_max_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_valid"}, o_in_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_x"}, o_x, 0);
        check({tag, "_x_addr"}, o_x_addr, 0);
        check({tag, "_g_addr"}, o_g_addr, 0);
        check({tag, "_err"}, o_err_code, 0);
        check({tag, "_rx"}, o_rx_count, 0);
        check({tag, "_mse"}, o_mse, 0);
        check({tag, "_cycles"}, o_cycles, 0);
        check({tag, "_max"}, o_max_err, 0);
    endtask

    task automatic set_errs(input int kind, input int big_idx, input int big_val);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       e_arr[k] = 0;
                1:       e_arr[k] = 2;
                default: e_arr[k] = $urandom_range(0, 6) - 3;
            endcase
        end
        if (big_idx >= 0) e_arr[big_idx] = big_val;
    endtask

    task automatic run_case(input int lat, input int mode, input int drop_at,
                            input int rst_at, input int glitch_at);
        bit     vin [0:4095];
        int     sent, out_idx, end_c, nres, exp_end, exp_err, exp_max, yv;
        longint exp_mse;
        bit     aborted;
        sent = 0; out_idx = 0; end_c = 0; aborted = 0;

        @(negedge clk);
        i_start = 1'b1; i_out_valid = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c < 3000; c++) begin
            vin[c] = o_in_valid;
            if (mode != M_DROP) check("in_valid", o_in_valid, (c <= N) ? 1 : 0);
            if (o_in_valid && sent < N) begin
                check("x", o_x, pat_x[sent]);
                sent++;
            end
            if (!o_busy) begin
                end_c = c;
                break;
            end
            if (c == rst_at) begin
                check("x_addr_mid", o_x_addr, rst_at);
                #2 rst = 1'b1;
                #1 check_all_zero("async_rst");
                #1 rst = 1'b0;
                aborted = 1;
                break;
            end
            if (c > lat && vin[c - lat] && mode != M_NEVER &&
                !(mode == M_DROP && out_idx >= drop_at)) begin
                yv          = int'(gold[out_idx]) + e_arr[out_idx];
                i_out_valid = 1'b1;
                i_y         = 16'(yv);
                out_idx++;
            end else begin
                i_out_valid = 1'b0;
                i_y         = 16'($urandom);
            end
            i_start = (c == glitch_at);
            @(negedge clk);
        end

        if (aborted) begin
            i_out_valid = 1'b1;
            repeat (2) @(negedge clk);
            i_out_valid = 1'b0;
            check("post_rst_busy", o_busy, 0);
            check("post_rst_rx", o_rx_count, 0);
            check("post_rst_mse", o_mse, 0);
            return;
        end

        nres    = (mode == M_NORMAL) ? N : (mode == M_DROP) ? drop_at : 0;
        exp_err = (mode == M_NORMAL) ? 0 : (mode == M_DROP) ? 2 : 1;
        exp_end = (mode == M_NORMAL) ? lat + N + 1 :
                  (mode == M_DROP)   ? lat + drop_at + 2 : TMO + 1;
        exp_mse = 0; exp_max = 0;
        for (int k = 0; k < nres; k++) begin
            exp_mse += longint'(e_arr[k]) * longint'(e_arr[k]);
            if ((e_arr[k] < 0 ? -e_arr[k] : e_arr[k]) > exp_max)
                exp_max = (e_arr[k] < 0) ? -e_arr[k] : e_arr[k];
        end
`ifndef SIGDRV_MAXERR_EN
        exp_max = 0;
`endif

        // Results arriving after the run ends must be ignored.
        for (int h = 0; h < 3; h++) begin
            i_out_valid = 1'b1;
            i_y         = 16'($urandom);
            @(negedge clk);
        end
        i_out_valid = 1'b0;

        check("end_cycle", end_c, exp_end);
        if (mode != M_DROP) check("sent", sent, N);
        check("done", o_done, (mode == M_NORMAL) ? 1 : 0);
        check("busy", o_busy, 0);
        check("in_valid_end", o_in_valid, 0);
        check("err_code", o_err_code, exp_err);
        check("rx_count", o_rx_count, nres);
        check("mse", o_mse, exp_mse);
        check("max_err", o_max_err, exp_max);
        if (mode == M_NORMAL) check("cycles", o_cycles, lat + N);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_out_valid = 1'b0; i_y = '0;
        for (int k = 0; k < N; k++) begin
            pat_x[k] = 8'($urandom);
            gold[k]  = 16'(400 + $urandom_range(0, 64000));
        end
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        set_errs(0, -1, 0);
        run_case(3, M_NORMAL, 0, -1, -1);

        set_errs(1, -1, 0);
        run_case(3, M_NORMAL, 0, -1, -1);

        set_errs(0, $urandom_range(0, N - 1), 300);
        run_case(1, M_NORMAL, 0, -1, -1);

        set_errs(2, $urandom_range(0, N - 1), -300);
        run_case($urandom_range(1, 8), M_NORMAL, 0, -1, 20);

        set_errs(2, -1, 0);
        run_case(3, M_DROP, 100, -1, -1);

        run_case(3, M_NEVER, 0, -1, -1);

        set_errs(2, -1, 0);
        run_case(3, M_NORMAL, 0, 50, -1);

        set_errs(2, -1, 0);
        run_case($urandom_range(1, 8), M_NORMAL, 0, -1, -1);

        set_errs(2, $urandom_range(0, 40), 77);
        run_case($urandom_range(1, 8), M_DROP, $urandom_range(1, N - 1), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sigmoid_stim_checker.md
SIGMOID_STIM_CHECKER -- requirements
Module: sigmoid_stim_checker

Interface
REQ-001: Parameter N_PAT, default 256; number of patterns per run (1..256).
REQ-002: Parameter TIMEOUT, default 1024; cycles allowed from run start to first i_out_valid.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: i_start  input  1  starts a run when sampled high in IDLE, DONE or ERR.
REQ-006: o_x_addr  output  8  input-pattern ROM address (combinational read).
REQ-007: i_pat_x  input  8  stimulus byte at o_x_addr, same cycle.
REQ-008: o_g_addr  output  8  golden ROM address (combinational read).
REQ-009: i_gold_y  input  16  golden value at o_g_addr, same cycle.
REQ-010: o_x  output  8  stimulus to sigmoid DUT i_x.
REQ-011: o_in_valid  output  1  drives DUT i_in_valid.
REQ-012: i_out_valid  input  1  from DUT o_out_valid.
REQ-013: i_y  input  16  from DUT o_y.
REQ-014: o_busy  output  1  high in RUN.
REQ-015: o_done  output  1  high in DONE.
REQ-016: o_err_code  output  2  00 none, 01 timeout, 10 valid dropped.
REQ-017: o_rx_count  output  9  results accepted this run.
REQ-018: o_mse  output  40  sum of squared |i_y - i_gold_y|, unscaled.
REQ-019: o_cycles  output  16  cycles from first o_in_valid to last accepted result, inclusive; saturates at 65535.
REQ-020: o_max_err  output  16  largest |i_y - i_gold_y| this run (see Configuration).

Function
REQ-021: FSM states IDLE, RUN, DONE, ERR; IDLE/DONE/ERR -> RUN on edge sampling i_start=1; i_start ignored in RUN.
REQ-022: Entering RUN clears o_rx_count, o_mse, o_cycles, o_max_err, o_err_code, send counter sc, and timeout counter.
REQ-023: Send: o_x_addr = sc; at the RUN-entry edge and each later RUN edge with sc<N_PAT, o_x <= i_pat_x, o_in_valid <= 1, sc++; o_in_valid therefore high exactly N_PAT consecutive cycles starting the cycle after i_start is sampled, then 0 with o_x holding last value.
REQ-024: Receive: o_g_addr = o_rx_count[7:0]; each RUN edge with i_out_valid=1 and o_rx_count<N_PAT accumulates diff*diff into o_mse (40-bit, no overflow at N_PAT=256) and increments o_rx_count.
REQ-025: After first accepted result, an edge in RUN with i_out_valid=0 and o_rx_count<N_PAT -> ERR, o_err_code=10; counters freeze.
REQ-026: No i_out_valid within TIMEOUT RUN cycles of entry -> ERR, o_err_code=01.
REQ-027: o_cycles increments every RUN edge from the first o_in_valid cycle; o_rx_count reaching N_PAT -> DONE; final o_cycles = DUT latency + N_PAT.
REQ-028: i_out_valid in IDLE, DONE, ERR ignored; outputs hold in DONE/ERR until next start.
REQ-029: Send and receive run concurrently; i_out_valid on the same edge as a send is accepted normally.

Reset
REQ-030: rst=1 immediately forces IDLE; o_in_valid, o_busy, o_done=0; o_x, o_x_addr, o_g_addr, o_err_code, o_rx_count, o_mse, o_cycles, o_max_err=0; mid-run reset aborts without further accumulation.

Configuration
REQ-031: Macro SIGDRV_MAXERR_EN defined: o_max_err tracks max absolute difference per accepted result; undefined: no comparator logic, o_max_err tied to 0.

Verification
REQ-032: DUT model latency 3, i_y=gold for all 256 -> o_done=1, o_mse=0, o_rx_count=256, o_cycles=259, o_err_code=00.
REQ-033: DUT model returns gold+2 for every pattern -> o_mse=1024, o_done=1.
REQ-034: DUT model deasserts valid at result 100 -> ERR, o_err_code=10, o_rx_count=100.
REQ-035: DUT never asserts valid -> ERR with o_err_code=01 after 1024 RUN cycles, o_in_valid low after 256 cycles.
REQ-036: rst pulsed during send of pattern 50 -> o_in_valid=0 and all outputs 0 without waiting for clk; next i_start restarts from pattern 0.
REQ-037: SIGDRV_MAXERR_EN defined, one result off by 300 -> o_max_err=300, o_mse=90000; undefined -> o_max_err=0.
